// File: rtl/jtframe_rom_nslots.sv
// rtl/jtframe_rom_nslots.sv - N read-only slots, each caching one 16-bit word, sharing one SDRAM read port
// A single outstanding SDRAM read is granted by fixed priority or round-robin; clr invalidates all caches.
module jtframe_rom_nslots #(
    parameter int NSLOT  = 5,
    parameter int SDRAMW = 22,
    parameter int AW     = 22,
    parameter int RROBIN = 0,
    parameter logic [NSLOT*SDRAMW-1:0] OFFSETS = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic [NSLOT-1:0]    slot_cs,
    input  logic [NSLOT*AW-1:0] slot_addr,
    output logic [NSLOT*16-1:0] slot_dout,
    output logic [NSLOT-1:0]    slot_ok,
    output logic                sdram_req,
    output logic [SDRAMW-1:0]   sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [15:0]         data_read,
    output logic                spurious
);
    localparam int GW = NSLOT > 1 ? $clog2(NSLOT) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]        state;
    logic [NSLOT-1:0]  valid;
    logic [AW-1:0]     tag  [NSLOT];
    logic [15:0]       data [NSLOT];
    logic [GW-1:0]     grant, rr, sel, rr_nxt;
    logic [AW-1:0]     gaddr, sel_addr;
    logic [SDRAMW-1:0] sel_off;
    logic              drop, any_pend, done, write_ok;
    logic [NSLOT-1:0]  pend;

    // Hits are masked while clr is high so a slot being invalidated never reports stale data.
    genvar gn;
    generate
        for (gn = 0; gn < NSLOT; gn++) begin : g_slot
            assign slot_ok[gn] = slot_cs[gn] & valid[gn] & ~clr
                               & (tag[gn] == slot_addr[gn*AW +: AW]);
            assign pend[gn]    = slot_cs[gn] & ~slot_ok[gn];
            assign slot_dout[gn*16 +: 16] = data[gn];
        end
    endgenerate

    always_comb begin
        int idx;
        idx      = 0;
        sel      = '0;
        sel_addr = '0;
        sel_off  = '0;
        any_pend = 1'b0;
        for (int i = 0; i < NSLOT; i++) begin
            idx = (RROBIN != 0) ? (int'(rr) + i) % NSLOT : i;
            if (!any_pend && pend[idx]) begin
                any_pend = 1'b1;
                sel      = GW'(idx);
                sel_addr = slot_addr[idx*AW +: AW];
                sel_off  = OFFSETS[idx*SDRAMW +: SDRAMW];
            end
        end
    end

    assign rr_nxt   = (int'(sel) == NSLOT - 1) ? '0 : sel + GW'(1);
    // Data arriving in REQ (before or with ack) completes the transaction just like in WAIT.
    assign done     = (state != IDLE) && data_rdy;
    assign write_ok = !drop && !clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            spurious   <= 1'b0;
            rr         <= '0;
            drop       <= 1'b0;
            valid      <= '0;
            grant      <= '0;
            gaddr      <= '0;
            for (int n = 0; n < NSLOT; n++) begin
                tag[n]  <= '0;
                data[n] <= '0;
            end
        end else begin
            if (clr) valid <= '0;
            if (done) begin
                state     <= IDLE;
                sdram_req <= 1'b0;
                drop      <= 1'b0;
                if (write_ok) begin
                    valid[grant] <= 1'b1;
                    tag[grant]   <= gaddr;
                    data[grant]  <= data_read;
                end
            end else begin
                if (clr && state != IDLE) drop <= 1'b1;
                case (state)
                    IDLE: begin
                        if (data_rdy) begin
                            spurious <= 1'b1;
                        end else if (any_pend) begin
                            grant      <= sel;
                            gaddr      <= sel_addr;
                            sdram_addr <= SDRAMW'(sel_addr) + sel_off;
                            sdram_req  <= 1'b1;
                            rr         <= rr_nxt;
                            state      <= REQ;
                        end
                    end
                    REQ: begin
                        if (sdram_ack) begin
                            sdram_req <= 1'b0;
                            state     <= WAIT;
                        end
                    end
                    WAIT: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_jtframe_rom_nslots.sv
// tb/tb_jtframe_rom_nslots.sv - directed bench: fixed-priority instance with offsets, round-robin instance
module tb_jtframe_rom_nslots;
    localparam int NS = 5;
    localparam int SW = 22;
    localparam int AW = 22;
    localparam logic [NS*SW-1:0] OFFS = {22'h0, 22'h0, 22'h100000, 22'h0, 22'h0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic            clr0, req0, ack0, rdy0, spur0;
    logic [NS-1:0]   cs0, ok0;
    logic [NS*AW-1:0] addr0;
    logic [NS*16-1:0] dout0;
    logic [SW-1:0]   saddr0;
    logic [15:0]     rdata0;

    logic            clr1, req1, ack1, rdy1, spur1;
    logic [NS-1:0]   cs1, ok1;
    logic [NS*AW-1:0] addr1;
    logic [NS*16-1:0] dout1;
    logic [SW-1:0]   saddr1;
    logic [15:0]     rdata1;

    jtframe_rom_nslots #(.NSLOT(NS), .SDRAMW(SW), .AW(AW), .RROBIN(0), .OFFSETS(OFFS)) dut0 (
        .clk(clk), .rst(rst), .clr(clr0), .slot_cs(cs0), .slot_addr(addr0),
        .slot_dout(dout0), .slot_ok(ok0), .sdram_req(req0), .sdram_addr(saddr0),
        .sdram_ack(ack0), .data_rdy(rdy0), .data_read(rdata0), .spurious(spur0)
    );

    jtframe_rom_nslots #(.NSLOT(NS), .SDRAMW(SW), .AW(AW), .RROBIN(1), .OFFSETS('0)) dut1 (
        .clk(clk), .rst(rst), .clr(clr1), .slot_cs(cs1), .slot_addr(addr1),
        .slot_dout(dout1), .slot_ok(ok1), .sdram_req(req1), .sdram_addr(saddr1),
        .sdram_ack(ack1), .data_rdy(rdy1), .data_read(rdata1), .spurious(spur1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_req0(input string tag);
        int cnt = 0;
        while (!req0 && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, " req"}, 32'(req0), 32'd1);
    endtask

    task automatic serve0(input string tag, input logic [21:0] a, input logic [15:0] d);
        wait_req0(tag);
        check({tag, " addr"}, 32'(saddr0), 32'(a));
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        check({tag, " req clear"}, 32'(req0), 32'd0);
        rdy0   = 1'b1;
        rdata0 = d;
        @(negedge clk);
        rdy0 = 1'b0;
    endtask

    initial begin
        int exp_g [6];
        exp_g = '{0, 1, 4, 0, 1, 4};
        clr0 = 0; cs0 = '0; addr0 = '0; ack0 = 0; rdy0 = 0; rdata0 = '0;
        clr1 = 0; cs1 = '0; addr1 = '0; ack1 = 0; rdy1 = 0; rdata1 = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst req", 32'(req0), 32'd0);
        check("rst addr", 32'(saddr0), 32'd0);
        check("rst spurious", 32'(spur0), 32'd0);
        check("rst dout", 32'(dout0[31:0]), 32'd0);
        check("rst dout hi", 32'(dout0[79:32]), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Offset applied, then a cached re-read with no new request
        cs0[2] = 1'b1; addr0[2*AW +: AW] = 22'h10;
        @(negedge clk);
        check("t1 ok before data", 32'(ok0[2]), 32'd0);
        serve0("t1", 22'h100010, 16'hBEEF);
        check("t1 ok", 32'(ok0[2]), 32'd1);
        check("t1 dout", 32'(dout0[2*16 +: 16]), 32'hBEEF);
        repeat (3) @(negedge clk);
        check("t1 no new req", 32'(req0), 32'd0);
        check("t1 ok held", 32'(ok0[2]), 32'd1);
        cs0 = '0;

        // Fixed priority: slot 1 before slot 3
        cs0 = 5'b01010; addr0[1*AW +: AW] = 22'h5; addr0[3*AW +: AW] = 22'h7;
        serve0("t2a", 22'h5, 16'h1111);
        check("t2 ok1", 32'(ok0[1]), 32'd1);
        check("t2 ok3 waits", 32'(ok0[3]), 32'd0);
        serve0("t2b", 22'h7, 16'h3333);
        check("t2 ok3", 32'(ok0[3]), 32'd1);
        check("t2 dout3", 32'(dout0[3*16 +: 16]), 32'h3333);
        cs0 = '0;

        // Address change mid-transaction: stored under the captured tag
        cs0 = 5'b00001; addr0[0 +: AW] = 22'h20;
        wait_req0("t4");
        check("t4 addr", 32'(saddr0), 32'h20);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        addr0[0 +: AW] = 22'h21;
        rdy0 = 1'b1; rdata0 = 16'hAAAA;
        @(negedge clk);
        rdy0 = 1'b0;
        check("t4 ok low", 32'(ok0[0]), 32'd0);
        check("t4 data stored", 32'(dout0[15:0]), 32'hAAAA);
        addr0[0 +: AW] = 22'h20;
        #1 check("t4 tag is 0x20", 32'(ok0[0]), 32'd1);
        addr0[0 +: AW] = 22'h21;
        serve0("t4b", 22'h21, 16'hBBBB);
        check("t4b ok", 32'(ok0[0]), 32'd1);
        check("t4b dout", 32'(dout0[15:0]), 32'hBBBB);
        cs0 = '0;

        // clr in WAIT: data dropped, caches invalidated, slot re-requested
        cs0 = 5'b10000; addr0[4*AW +: AW] = 22'h30;
        wait_req0("t5");
        check("t5 addr", 32'(saddr0), 32'h30);
        ack0 = 1'b1;
        @(negedge clk);
        ack0 = 1'b0;
        cs0[3] = 1'b1;
        #1 check("t5 slot3 hit before clr", 32'(ok0[3]), 32'd1);
        cs0[3] = 1'b0;
        clr0 = 1'b1;
        @(negedge clk);
        clr0 = 1'b0;
        rdy0 = 1'b1; rdata0 = 16'hDEAD;
        @(negedge clk);
        rdy0 = 1'b0;
        check("t5 ok all low", 32'(ok0), 32'd0);
        check("t5 dout4 not written", 32'(dout0[4*16 +: 16]), 32'd0);
        cs0[3] = 1'b1;
        #1 check("t5 slot3 invalid", 32'(ok0[3]), 32'd0);
        cs0[3] = 1'b0;
        @(negedge clk);
        check("t5 re-request", 32'(req0), 32'd1);
        serve0("t5b", 22'h30, 16'h4444);
        check("t5b ok", 32'(ok0[4]), 32'd1);
        check("t5b dout", 32'(dout0[4*16 +: 16]), 32'h4444);
        cs0 = '0;

        // Spurious data, then reset in REQ
        @(negedge clk);
        rdy0 = 1'b1;
        @(negedge clk);
        rdy0 = 1'b0;
        check("t6 spurious set", 32'(spur0), 32'd1);
        check("t6 no req", 32'(req0), 32'd0);
        repeat (3) @(negedge clk);
        check("t6 spurious sticky", 32'(spur0), 32'd1);
        cs0[0] = 1'b1; addr0[0 +: AW] = 22'h40;
        @(negedge clk);
        check("t6 req", 32'(req0), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6 rst req", 32'(req0), 32'd0);
        check("t6 rst spurious", 32'(spur0), 32'd0);
        check("t6 rst dout4", 32'(dout0[4*16 +: 16]), 32'd0);
        rst = 1'b0;
        cs0 = '0;
        rdy0 = 1'b1;
        @(negedge clk);
        rdy0 = 1'b0;
        check("t6 late data spurious", 32'(spur0), 32'd1);
        check("t6 late data no req", 32'(req0), 32'd0);

        // Round robin on the second instance
        cs1 = 5'b10011;
        addr1[0 +: AW] = 22'h0; addr1[1*AW +: AW] = 22'h1; addr1[4*AW +: AW] = 22'h4;
        for (int k = 0; k < 6; k++) begin
            int cnt = 0;
            while (!req1 && cnt < 20) begin
                @(negedge clk);
                cnt++;
            end
            check($sformatf("rr%0d req", k), 32'(req1), 32'd1);
            check($sformatf("rr%0d grant", k), 32'(saddr1), 32'(exp_g[k]));
            ack1 = 1'b1;
            @(negedge clk);
            ack1 = 1'b0;
            rdy1 = 1'b1; rdata1 = 16'h1000 + 16'(k);
            @(negedge clk);
            rdy1 = 1'b0;
            check($sformatf("rr%0d ok", k), 32'(ok1[exp_g[k]]), 32'd1);
            clr1 = 1'b1;
            @(negedge clk);
            clr1 = 1'b0;
        end
        cs1 = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/jtframe_rom_nslots.md
JTFRAME_ROM_NSLOTS -- requirements
Module: jtframe_rom_nslots

Interface
REQ-001 SHALL have parameter NSLOT, default 5, number of read-only slots, legal range 1..8.
REQ-002 SHALL have parameter SDRAMW, default 22, SDRAM word-address width.
REQ-003 SHALL have parameter AW, default 22, per-slot word-address width, AW<=SDRAMW.
REQ-004 SHALL have parameter RROBIN, default 0: 0 is fixed priority with slot 0 highest; 1 is round-robin.
REQ-005 SHALL have parameter OFFSETS [NSLOT*SDRAMW-1:0], default 0, with slot n's offset in bits [n*SDRAMW +: SDRAMW].
REQ-006 SHALL have clk  input  1  the single clock; all logic is on its rising edge.
REQ-007 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-008 SHALL have clr  input  1  synchronous invalidate of all slot caches.
REQ-009 SHALL have slot_cs  input  NSLOT  per-slot read enable.
REQ-010 SHALL have slot_addr  input  NSLOT*AW  packed per-slot word addresses.
REQ-011 SHALL have slot_dout  output  NSLOT*16  packed per-slot cached data.
REQ-012 SHALL have slot_ok  output  NSLOT  per-slot data-valid indication.
REQ-013 SHALL have sdram_req  output  1  request to the SDRAM controller.
REQ-014 SHALL have sdram_addr  output  SDRAMW  requested word address.
REQ-015 SHALL have sdram_ack  input  1  the controller has accepted the request.
REQ-016 SHALL have data_rdy  input  1  read data valid for one cycle.
REQ-017 SHALL have data_read  input  16  read data.
REQ-018 SHALL have spurious  output  1  sticky flag: data_rdy received with no outstanding request.

Function
REQ-019 SHALL hold, per slot, a cache entry: valid bit, AW-bit tag and 16-bit data.
REQ-020 SHALL drive slot_ok[n] combinationally as slot_cs[n] & valid[n] & (tag[n]==slot_addr[n]).
REQ-021 SHALL drive slot_dout[n] from cache data[n] at all times, independent of cs.
REQ-022 SHALL treat slot n as pending when slot_cs[n] is high and slot_ok[n] is low.
REQ-023 SHALL implement the states IDLE, REQ and WAIT.
REQ-024 In IDLE, with any slot pending, SHALL register grant=selected slot, gaddr=slot_addr[grant], sdram_addr=zero-extended gaddr + offset[grant] modulo 2^SDRAMW, set sdram_req=1 and go to REQ, all on the same edge.
REQ-025 In REQ, SHALL hold sdram_req and sdram_addr stable until sdram_ack, then clear sdram_req on that edge and go to WAIT.
REQ-026 If data_rdy arrives in REQ together with or before sdram_ack, SHALL treat it as the completion described for WAIT.
REQ-027 In WAIT, on data_rdy, SHALL write valid=1, tag=gaddr and data=data_read into slot grant, then return to IDLE.
REQ-028 SHALL keep the first slot_ok for a miss no earlier than the cycle after data_rdy, giving a minimum miss latency of 3 cycles from cs with an ack/rdy-ready controller.
REQ-029 SHALL start at most one outstanding SDRAM transaction at any time.
REQ-030 SHALL use the captured gaddr for the tag, so a slot address changed mid-transaction yields no hit and re-pends the slot.
REQ-031 With RROBIN=0, SHALL grant the lowest-index pending slot.
REQ-032 With RROBIN=1, SHALL grant the first pending slot at or after pointer rr, wrapping at NSLOT, and SHALL set rr=(grant+1) mod NSLOT on each grant.
REQ-033 SHALL reset rr to 0.
REQ-034 On clr, SHALL clear every valid bit on that edge.
REQ-035 On clr during REQ or WAIT, SHALL set a drop flag so the pending data_rdy completes the FSM but is not written.
REQ-036 SHALL clear the drop flag on return to IDLE.
REQ-037 On clr coinciding with data_rdy, SHALL discard that data.
REQ-038 SHALL block hits in a slot that is simultaneously being cleared.
REQ-039 SHALL set spurious on data_rdy in IDLE, keep the FSM unchanged, and clear spurious only on rst.

Reset
REQ-040 On rst, SHALL drive sdram_req=0, sdram_addr=0, spurious=0, state=IDLE, rr=0, drop=0, all valid=0 and slot_dout=0 on the next edge.
REQ-041 SHALL give rst priority over every other input.
REQ-042 SHALL abandon any in-flight transaction on rst and treat its later data_rdy as spurious.

Verification
REQ-043 Bench SHALL check: NSLOT=5, OFFSETS slot2=0x100000, slot2 cs addr 0x10 -> sdram_addr=0x100010, ack, data_rdy 0xBEEF -> slot_ok[2]=1 and dout2=0xBEEF; second read of the same address -> ok with no new sdram_req.
REQ-044 Bench SHALL check: RROBIN=0, slots 1 and 3 miss together -> slot 1 served first, then slot 3.
REQ-045 Bench SHALL check: RROBIN=1, slots 0, 1 and 4 missing continuously with each cache cleared after a hit -> grants 0,1,4,0,1,4.
REQ-046 Bench SHALL check: slot0 address changes from 0x20 to 0x21 in WAIT -> data stored with tag 0x20, ok stays low, a new request for 0x21 is issued.
REQ-047 Bench SHALL check: clr asserted in WAIT -> data_rdy is not written, all ok=0, FSM returns to IDLE and re-requests.
REQ-048 Bench SHALL check: data_rdy in IDLE -> spurious=1 and stays high until rst; rst in REQ -> sdram_req=0 on the next edge.
